uart_tx_queue: RTL and testbench

Byte queue and issue controller sitting directly upstream of the UART transmitter. Accepts bytes from the host side over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and feeds them one at a time to the transmitter's `newd`/`dintx` inputs. It holds `newd` long enough for the transmitter's slow bit clock to sample it, then waits for `donetx` before issuing the next byte. Everything runs in the system `clk` domain.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync_fifo.sv | 81 ++++++++
 rtl/uart_tx_queue.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_queue.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART transmit path.
//   - txq_state_e : issue-controller FSM states (IDLE, ASSERT, WAIT_DONE)
//   - CLK_FREQ_DEFAULT / BAUD_RATE_DEFAULT : default system clock and baud
//   - clkcount() : system clock cycles per bit-clock period; the transmitter
//     and the queue both derive their timing from this so they stay in step.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT  = 1000000;
  localparam int unsigned BAUD_RATE_DEFAULT = 9600;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    WAIT_DONE = 2'd2
  } txq_state_e;

  // Integer division matches the transmitter's own bit-clock divider.
  function automatic int unsigned clkcount(input int unsigned clkFreq,
                                           input int unsigned baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
//
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-low reset (empties the FIFO)
//   push_i   in   write data_i this cycle (ignored when full)
//   data_i   in   write data
//   pop_i    in   discard the head entry this cycle (ignored when empty)
//   data_o   out  head entry, valid whenever empty_o is low
//   full_o   out  level_o == DEPTH
//   empty_o  out  level_o == 0
//   level_o  out  entries currently stored
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rdPtr_q];

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; a simultaneous push and pop leaves
  // the count untouched.
  always_comb begin
    wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = doPop  ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (doPop && !doPush) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: stale contents are never visible because
  // emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue
//
// Byte queue and issue controller in front of the UART transmitter. Host bytes
// are accepted over a valid/ready handshake into a DEPTH-entry FIFO and handed
// one at a time to the transmitter: newd is held for HOLD_CYCLES clocks so the
// slow bit clock is sure to see it, then the controller waits for a rising
// edge on donetx before issuing the next byte.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   s_valid      in   host byte valid
//   s_data       in   host byte
//   s_ready      out  queue can accept (low while full or in reset)
//   newd         out  new-data request to the transmitter
//   dintx        out  byte presented to the transmitter
//   donetx       in   transmitter frame-done level
//   level        out  bytes currently queued
//   busy         out  controller is not in IDLE
//   sent         out  one-cycle pulse per completed frame
//   timeout_err  out  sticky watchdog flag
//
// Optional feature: define UART_TXQ_TIMEOUT_EN to enable a watchdog in
// WAIT_DONE. After TIMEOUT_CYCLES without a donetx edge the byte is dropped,
// timeout_err is set and the controller returns to IDLE. Without the macro
// timeout_err is tied low and WAIT_DONE waits indefinitely.
// ----------------------------------------------------------------------------
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD_RATE      = BAUD_RATE_DEFAULT,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned HOLD_CYCLES    = clkcount(CLK_FREQ, BAUD_RATE) + 2,
  parameter int unsigned TIMEOUT_CYCLES = 16 * clkcount(CLK_FREQ, BAUD_RATE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     newd,
  output logic [7:0]               dintx,
  input  logic                     donetx,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     sent,
  output logic                     timeout_err
);

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

  txq_state_e state_q;
  logic       newd_q;
  logic [7:0] dintx_q;
  logic       busy_q;
  logic       sent_q;
  logic       donePrev_q;
  logic [31:0] holdCnt_q, holdCnt_d;

  logic       fifoPush, fifoPop;
  logic       fifoFull, fifoEmpty;
  logic [7:0] fifoData;
  logic       doneRise;

  // Readiness looks only at the registered level, so a full queue refuses a
  // push even in a cycle where the controller pops.
  assign s_ready  = rst && !fifoFull;
  assign fifoPush = s_valid && s_ready;

  // The pop is issued in the same cycle the head byte is latched into dintx.
  assign fifoPop  = (state_q == IDLE) && !fifoEmpty;

  assign doneRise  = donetx && !donePrev_q;
  assign holdCnt_d = holdCnt_q + 32'd1;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .data_i  (s_data),
    .pop_i   (fifoPop),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (level)
  );

`ifdef UART_TXQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic        timeoutErr_q;
  logic [31:0] waitCnt_q, waitCnt_d;

  assign waitCnt_d   = waitCnt_q + 32'd1;
  assign timeout_err = timeoutErr_q;
`else
  logic unusedTimeoutCfg;

  assign unusedTimeoutCfg = ^(32'(TIMEOUT_CYCLES));
  assign timeout_err      = 1'b0;
`endif

  // Issue controller. The donetx history register updates every cycle so
  // edges that occur outside WAIT_DONE are absorbed rather than remembered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      newd_q     <= 1'b0;
      dintx_q    <= 8'h00;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      donePrev_q <= 1'b0;
      holdCnt_q  <= '0;
`ifdef UART_TXQ_TIMEOUT_EN
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
`endif
    end else begin
      donePrev_q <= donetx;
      sent_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifoEmpty) begin
            dintx_q   <= fifoData;
            newd_q    <= 1'b1;
            busy_q    <= 1'b1;
            holdCnt_q <= '0;
            state_q   <= ASSERT;
          end
        end
        ASSERT: begin
          if (holdCnt_q == HOLD_LAST) begin
            newd_q  <= 1'b0;
            state_q <= WAIT_DONE;
`ifdef UART_TXQ_TIMEOUT_EN
            waitCnt_q <= '0;
`endif
          end else begin
            holdCnt_q <= holdCnt_d;
          end
        end
        WAIT_DONE: begin
          if (doneRise) begin
            sent_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`ifdef UART_TXQ_TIMEOUT_EN
          else if (waitCnt_q == TIMEOUT_LAST) begin
            timeoutErr_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            waitCnt_q <= waitCnt_d;
          end
`endif
        end
        default: begin
          newd_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign newd  = newd_q;
  assign dintx = dintx_q;
  assign busy  = busy_q;
  assign sent  = sent_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Self-checking bench for uart_tx_queue at its default parameters
// (1 MHz clock, 9600 baud, DEPTH 16, newd held 106 cycles). The bench plays
// the transmitter's part by driving donetx, and keeps a queue of the bytes
// it expects to be issued in order.
// ----------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int HOLD    = 106;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 1664;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       newd;
  logic [7:0] dintx;
  logic       donetx = 1'b0;
  logic [4:0] level;
  logic       busy;
  logic       sent;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit         rose = 1'b0;
  bit         lastNewd = 1'b0;
  int         holdCnt = 0;

  always #5 clk = ~clk;

  uart_tx_queue dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .newd        (newd),
    .dintx       (dintx),
    .donetx      (donetx),
    .level       (level),
    .busy        (busy),
    .sent        (sent),
    .timeout_err (timeout_err)
  );

  // Advance to the next falling edge and note whether newd has just risen
  // and how many sampled cycles it has been high for.
  task automatic step();
    @(negedge clk);
    rose = newd && !lastNewd;
    lastNewd = newd;
    if (newd) begin
      if (rose) holdCnt = 1;
      else holdCnt++;
    end
  endtask

  // A byte has just been handed to the transmitter: it must be the oldest
  // byte the bench queued, and the queue must have shrunk by one.
  task automatic verify_issue();
    logic [7:0] expB;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_issue: dintx=%h issued with nothing queued", dintx);
    end else begin
      expB = q.pop_front();
      if (dintx !== expB) begin
        errors++;
        $display("[TB] FAIL issue_order: dintx=%h expected %h", dintx, expB);
      end
    end
    checks++;
    if (level !== 5'(q.size())) begin
      errors++;
      $display("[TB] FAIL issue_level: level=%0d expected %0d", level, q.size());
    end
  endtask

  // Offer one byte for one cycle; the model accepts it whenever it holds
  // fewer than DEPTH bytes.
  task automatic applyStimulus(input logic [7:0] d, output bit accepted);
    accepted = (q.size() < DEPTH);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    if (accepted) q.push_back(d);
    if (rose) verify_issue();
  endtask

  // Act as the transmitter for one byte: wait for the issue if it has not
  // happened yet, measure the newd hold time, then finish the frame.
  task automatic serve_byte(input bit injectEarly);
    int  guard;
    bit  sawSent;
    if (!lastNewd) begin
      guard = 0;
      do begin
        step();
        guard++;
      end while (!rose && guard < 400);
      checks++;
      if (!rose) begin
        errors++;
        $display("[TB] FAIL issue_timeout: newd=%b after %0d cycles, expected 1", newd, guard);
        return;
      end
      verify_issue();
    end
    guard = 0;
    sawSent = 1'b0;
    while (newd && guard < 300) begin
      step();
      guard++;
      if (injectEarly && holdCnt == 10) donetx = 1'b1;
      if (injectEarly && holdCnt == 12) donetx = 1'b0;
      if (sent !== 1'b0) sawSent = 1'b1;
    end
    donetx = 1'b0;
    checks++;
    if (holdCnt != HOLD) begin
      errors++;
      $display("[TB] FAIL hold_cycles: newd high %0d cycles, expected %0d", holdCnt, HOLD);
    end
    checks++;
    if (sawSent) begin
      errors++;
      $display("[TB] FAIL sent_during_hold: sent seen=1, expected 0");
    end
    repeat ($urandom_range(0, 4)) step();
    checks++;
    if (busy !== 1'b1 || sent !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_done: busy=%b sent=%b, expected busy=1 sent=0", busy, sent);
    end
    donetx = 1'b1;
    step();
    donetx = 1'b0;
    checks++;
    if (sent !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sent_pulse: sent=%b busy=%b, expected sent=1 busy=0", sent, busy);
    end
    step();
    checks++;
    if (sent !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sent_width: sent=%b, expected 0", sent);
    end
    if (rose) verify_issue();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (newd !== 1'b0 || dintx !== 8'h00 || busy !== 1'b0 || sent !== 1'b0 ||
        level !== 5'd0 || s_ready !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: newd=%b dintx=%h busy=%b sent=%b level=%0d s_ready=%b terr=%b, expected 0 00 0 0 0 0 0",
               newd, dintx, busy, sent, level, s_ready, timeout_err);
    end
    rst = 1'b1;
    step();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: s_ready=%b, expected 1", s_ready);
    end
  endtask

  task automatic test_single_byte();
    bit acc;
    applyStimulus(8'hA5, acc);
    checks++;
    if (level !== 5'd1 || newd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_push: level=%0d newd=%b, expected level=1 newd=0", level, newd);
    end
    serve_byte(1'b0);
    checks++;
    if (level !== 5'd0 || busy !== 1'b0 || newd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: level=%0d busy=%b newd=%b, expected 0 0 0", level, busy, newd);
    end
  endtask

  task automatic test_burst_full();
    bit acc;
    int nAcc = 0;
    bit readyOk = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (s_ready !== (q.size() != DEPTH)) readyOk = 1'b0;
      applyStimulus(8'(i), acc);
      if (acc) nAcc++;
    end
    checks++;
    if (!readyOk) begin
      errors++;
      $display("[TB] FAIL burst_ready: s_ready did not track level < %0d", DEPTH);
    end
    checks++;
    if (nAcc != 17 || level !== 5'd16 || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst_fill: accepted=%0d level=%0d s_ready=%b, expected 17 16 0", nAcc, level, s_ready);
    end
  endtask

  task automatic test_full_push_pop();
    int guard = 0;
    while (newd && guard < 300) begin
      step();
      guard++;
    end
    checks++;
    if (holdCnt != HOLD) begin
      errors++;
      $display("[TB] FAIL burst_hold: newd high %0d cycles, expected %0d", holdCnt, HOLD);
    end
    s_valid = 1'b1;
    s_data  = 8'hEE;
    donetx  = 1'b1;
    step();
    donetx  = 1'b0;
    checks++;
    if (sent !== 1'b1 || level !== 5'd16 || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_pre_pop: sent=%b level=%0d s_ready=%b, expected 1 16 0", sent, level, s_ready);
    end
    step();
    s_valid = 1'b0;
    checks++;
    if (level !== 5'd15 || !rose) begin
      errors++;
      $display("[TB] FAIL full_push_pop: level=%0d newd_rose=%b, expected 15 1", level, rose);
    end
    if (rose) verify_issue();
    for (int i = 0; i < 16; i++) serve_byte(1'b0);
    checks++;
    if (level !== 5'd0 || busy !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("[TB] FAIL burst_drain: level=%0d busy=%b left=%0d, expected 0 0 0", level, busy, q.size());
    end
  endtask

  task automatic test_donetx_ignored();
    bit acc;
    applyStimulus(8'($urandom), acc);
    serve_byte(1'b1);
  endtask

  task automatic test_random();
    bit acc;
    int k;
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) applyStimulus(8'($urandom), acc);
      for (int i = 0; i < k; i++) serve_byte(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_reset_mid_byte();
    bit acc;
    bit activity = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), acc);
    repeat (20) step();
    checks++;
    if (newd !== 1'b1 || level !== 5'd3) begin
      errors++;
      $display("[TB] FAIL mid_byte_setup: newd=%b level=%0d, expected 1 3", newd, level);
    end
    rst = 1'b0;
    step();
    checks++;
    if (newd !== 1'b0 || level !== 5'd0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_byte_reset: newd=%b level=%0d busy=%b s_ready=%b, expected 0 0 0 0",
               newd, level, busy, s_ready);
    end
    rst = 1'b1;
    q.delete();
    repeat (150) begin
      step();
      if (newd !== 1'b0 || busy !== 1'b0 || level !== 5'd0) activity = 1'b1;
    end
    checks++;
    if (activity) begin
      errors++;
      $display("[TB] FAIL post_reset_quiet: activity=1 after reset, expected 0");
    end
  endtask

  task automatic test_timeout();
    bit acc;
    int guard;
    applyStimulus(8'h3C, acc);
    guard = 0;
    do begin
      step();
      guard++;
    end while (!rose && guard < 50);
    if (rose) verify_issue();
    guard = 0;
    while (newd && guard < 300) begin
      step();
      guard++;
    end
`ifdef UART_TXQ_TIMEOUT_EN
    guard = 0;
    while (timeout_err !== 1'b1 && guard < 3000) begin
      step();
      guard++;
    end
    checks++;
    if (guard != TIMEOUT || busy !== 1'b0 || sent !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_fire: cycles=%0d busy=%b sent=%b, expected %0d 0 0", guard, busy, sent, TIMEOUT);
    end
    applyStimulus(8'hC3, acc);
    serve_byte(1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: timeout_err=%b, expected 1", timeout_err);
    end
`else
    begin
      bit stuckOk = 1'b1;
      repeat (TIMEOUT + 300) begin
        step();
        if (busy !== 1'b1 || timeout_err !== 1'b0 || sent !== 1'b0) stuckOk = 1'b0;
      end
      checks++;
      if (!stuckOk) begin
        errors++;
        $display("[TB] FAIL no_timeout: busy=%b terr=%b, expected busy=1 terr=0 throughout", busy, timeout_err);
      end
      donetx = 1'b1;
      step();
      donetx = 1'b0;
      checks++;
      if (sent !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL late_done: sent=%b busy=%b, expected 1 0", sent, busy);
      end
      step();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst_full();
    test_full_push_pop();
    test_donetx_ignored();
    test_random();
    test_reset_mid_byte();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL global_timeout: simulation time limit reached, expected completion");
    $fatal(1, "[TB] time limit");
  end

endmodule
